// File: rtl/int_wb_merge_if.sv
`default_nettype none
// ============================================================================
// Interface : int_wb_merge_if
// Purpose   : Pipeline/divider result inputs and merged write-back outputs
//             of int_wb_merge.
// Revision  : 1.0
// ============================================================================
interface int_wb_merge_if #(
    parameter int WIDTH = 32
);
    logic             clear;
    logic             pipe_valid;
    logic             pipe_we;
    logic [4:0]       pipe_rd;
    logic [WIDTH-1:0] pipe_data;
    logic             div_done;
    logic [4:0]       div_rd;
    logic [WIDTH-1:0] div_result;
    logic [4:0]       div_busy_rd;
    logic             div_stall;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             pipe_hold;
    logic             raw_hazard;
    logic             buf_full;

    modport master (
        output clear, pipe_valid, pipe_we, pipe_rd, pipe_data,
        output div_done, div_rd, div_result, div_busy_rd, div_stall,
        output rs1, rs2,
        input  wb_valid, wb_rd, wb_data, pipe_hold, raw_hazard, buf_full
    );

    modport slave (
        input  clear, pipe_valid, pipe_we, pipe_rd, pipe_data,
        input  div_done, div_rd, div_result, div_busy_rd, div_stall,
        input  rs1, rs2,
        output wb_valid, wb_rd, wb_data, pipe_hold, raw_hazard, buf_full
    );
endinterface
`default_nettype wire

// File: rtl/int_wb_merge.sv
`default_nettype none
// ============================================================================
// Module    : int_wb_merge
// Purpose   : Merges main-pipeline results and buffered divider results onto
//             a single register-file write port with anti-starvation.
// Revision  : 1.0
// ============================================================================
module int_wb_merge #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input wire            clk,
    input wire            rst,
    int_wb_merge_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_MAX);

    logic [4:0]         r_fifo_rd   [DEPTH];
    logic [WIDTH-1:0]   r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_STV_W-1:0] r_starve;
    logic               r_wb_valid;
    logic [4:0]         r_wb_rd;
    logic [WIDTH-1:0]   r_wb_data;

    logic             w_empty;
    logic             w_full;
    logic             w_pipe_cand;
    logic             w_force;
    logic             w_sel_fifo;
    logic             w_sel_pipe;
    logic             w_push;
    logic [DEPTH-1:0] w_hit_rs1;
    logic [DEPTH-1:0] w_hit_rs2;
    logic             w_raw_rs1;
    logic             w_raw_rs2;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_pipe_cand = bus.pipe_valid && bus.pipe_we && (bus.pipe_rd != 5'd0);
    assign w_force     = !w_empty && (r_starve == c_STARVE_MAX);

    // The buffer wins when starved, when full against the pipe, or when the pipe is idle.
    assign w_sel_fifo  = w_force || (w_full && w_pipe_cand) || (!w_pipe_cand && !w_empty);
    assign w_sel_pipe  = w_pipe_cand && !w_sel_fifo;

    assign w_push = bus.div_done && (bus.div_rd != 5'd0) && !bus.clear && (!w_full || w_sel_fifo);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [c_PTR_W-1:0] w_age;
        logic               w_live;
        assign w_age        = c_PTR_W'(i) - r_rd_ptr;
        assign w_live       = ({1'b0, w_age} < r_count);
        assign w_hit_rs1[i] = w_live && (r_fifo_rd[i] == bus.rs1);
        assign w_hit_rs2[i] = w_live && (r_fifo_rd[i] == bus.rs2);
    end

    assign w_raw_rs1 = (bus.rs1 != 5'd0) &&
                       ((|w_hit_rs1) ||
                        (bus.div_stall && (bus.div_busy_rd == bus.rs1)) ||
                        (bus.div_done  && (bus.div_rd      == bus.rs1)));
    assign w_raw_rs2 = (bus.rs2 != 5'd0) &&
                       ((|w_hit_rs2) ||
                        (bus.div_stall && (bus.div_busy_rd == bus.rs2)) ||
                        (bus.div_done  && (bus.div_rd      == bus.rs2)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
        end else if (bus.clear) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            if (w_sel_fifo) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_sel_fifo};

            // A non-empty buffer that is not popped has lost to the pipe.
            if (w_sel_fifo || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end

            if (w_sel_fifo) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_fifo_rd[r_rd_ptr];
                r_wb_data  <= r_fifo_data[r_rd_ptr];
            end else if (w_sel_pipe) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= bus.pipe_rd;
                r_wb_data  <= bus.pipe_data;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.div_rd;
            r_fifo_data[r_wr_ptr] <= bus.div_result;
        end
    end

    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.wb_data    = r_wb_data;
    assign bus.pipe_hold  = w_pipe_cand && w_sel_fifo;
    assign bus.raw_hazard = w_raw_rs1 || w_raw_rs2;
    assign bus.buf_full   = w_full;
endmodule
`default_nettype wire

// File: tb/tb_int_wb_merge.sv
`default_nettype none
// ============================================================================
// Module    : tb_int_wb_merge
// Purpose   : Directed and randomized self-checking bench for int_wb_merge.
// Revision  : 1.0
// ============================================================================
module tb_int_wb_merge;
    localparam int c_W  = 32;
    localparam int c_D  = 2;
    localparam int c_SM = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    int_wb_merge_if #(.WIDTH(c_W)) bus ();

    int_wb_merge #(.WIDTH(c_W), .DEPTH(c_D), .STARVE_MAX(c_SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: ordered queue of buffered divider results.
    logic [4:0]     q_rd   [$];
    logic [c_W-1:0] q_data [$];
    int             starve;
    logic           e_valid;
    logic [4:0]     e_rd;
    logic [c_W-1:0] e_data;
    logic           m_hold;
    logic           m_full;
    logic           m_haz;
    int             m_win; // 0 none, 1 pipe, 2 buffer

    function automatic bit dep(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q_rd[k]) if (q_rd[k] == r) return 1'b1;
        if (bus.div_stall && bus.div_busy_rd == r) return 1'b1;
        if (bus.div_done && bus.div_rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_comb();
        bit cand;
        int n;
        cand = bus.pipe_valid && bus.pipe_we && (bus.pipe_rd != 5'd0);
        n    = q_rd.size();
        if (n > 0 && starve == c_SM) m_win = 2;
        else if (n == c_D && cand)   m_win = 2;
        else if (cand)               m_win = 1;
        else if (n > 0)              m_win = 2;
        else                         m_win = 0;
        m_hold = cand && (m_win == 2);
        m_full = (n == c_D);
        m_haz  = dep(bus.rs1) || dep(bus.rs2);
    endfunction

    task automatic reset_model();
        q_rd.delete();
        q_data.delete();
        starve  = 0;
        e_valid = 1'b0;
        e_rd    = 5'd0;
        e_data  = '0;
    endtask

    task automatic tick();
        bit was_empty;
        model_comb();
        @(posedge clk);
        was_empty = (q_rd.size() == 0);
        if (bus.clear) begin
            q_rd.delete();
            q_data.delete();
            starve  = 0;
            e_valid = 1'b0;
        end else begin
            if (m_win == 2) begin
                e_valid = 1'b1;
                e_rd    = q_rd.pop_front();
                e_data  = q_data.pop_front();
            end else if (m_win == 1) begin
                e_valid = 1'b1;
                e_rd    = bus.pipe_rd;
                e_data  = bus.pipe_data;
            end else begin
                e_valid = 1'b0;
            end
            if (m_win == 2 || was_empty) starve = 0;
            else if (starve < c_SM) starve++;
            if (bus.div_done && bus.div_rd != 5'd0) begin
                vectors++;
                if (q_rd.size() == c_D) begin
                    errors++;
                    $display("FAIL push_into_full: occupancy %0d required below %0d", q_rd.size(), c_D);
                end else begin
                    q_rd.push_back(bus.div_rd);
                    q_data.push_back(bus.div_result);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.clear       = 1'b0;
        bus.pipe_valid  = 1'b0;
        bus.pipe_we     = 1'b0;
        bus.pipe_rd     = 5'd0;
        bus.pipe_data   = '0;
        bus.div_done    = 1'b0;
        bus.div_rd      = 5'd0;
        bus.div_result  = '0;
        bus.div_busy_rd = 5'd0;
        bus.div_stall   = 1'b0;
        bus.rs1         = 5'd0;
        bus.rs2         = 5'd0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [c_W-1:0] data);
        bus.pipe_valid = 1'b1;
        bus.pipe_we    = 1'b1;
        bus.pipe_rd    = rd;
        bus.pipe_data  = data;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", bus.wb_valid); end
        vectors++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d required 0", bus.wb_rd); end
        vectors++; if (bus.wb_data !== '0) begin errors++; $display("FAIL rst_data: got %0h required 0", bus.wb_data); end
        vectors++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %0b required 0", bus.pipe_hold); end
        vectors++; if (bus.buf_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b required 0", bus.buf_full); end
        rst = 1'b1;
        reset_model();
    endtask

    task automatic test_single_div();
        idle();
        bus.div_done = 1'b1; bus.div_rd = 5'd5; bus.div_result = 32'h0000_0007;
        #1;
        vectors++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL div1_hold0: got %0b required 0", bus.pipe_hold); end
        tick();
        idle(); #1;
        vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL div1_early: got %0b required 0", bus.wb_valid); end
        vectors++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL div1_hold1: got %0b required 0", bus.pipe_hold); end
        tick();
        vectors++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'd7})
            begin errors++; $display("FAIL div1_wb: got %0b/%0d/%0h required 1/5/7", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL div1_after: got %0b required 0", bus.wb_valid); end
    endtask

    task automatic test_coincident();
        idle();
        bus.div_done = 1'b1; bus.div_rd = 5'd3; bus.div_result = 32'hAAAA_AAAA;
        pipe(5'd4, 32'h1234);
        #1;
        vectors++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL coin_hold: got %0b required 0", bus.pipe_hold); end
        tick();
        idle();
        vectors++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd4, 32'h1234})
            begin errors++; $display("FAIL coin_pipe: got %0b/%0d/%0h required 1/4/1234", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tick();
        vectors++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd3, 32'hAAAA_AAAA})
            begin errors++; $display("FAIL coin_div: got %0b/%0d/%0h required 1/3/aaaaaaaa", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tick();
    endtask

    task automatic test_starve();
        idle();
        bus.div_done = 1'b1; bus.div_rd = 5'd6; bus.div_result = 32'h66;
        pipe(5'd1, 32'h100);
        tick();
        for (int i = 1; i <= 6; i++) begin
            idle();
            pipe(5'd2, 32'(i));
            #1;
            vectors++; if (bus.pipe_hold !== (i == 5))
                begin errors++; $display("FAIL starve_hold[%0d]: got %0b required %0b", i, bus.pipe_hold, (i == 5)); end
            tick();
            vectors++; if (bus.wb_rd !== ((i == 5) ? 5'd6 : 5'd2))
                begin errors++; $display("FAIL starve_rd[%0d]: got %0d required %0d", i, bus.wb_rd, (i == 5) ? 6 : 2); end
        end
        idle();
        tick();
    endtask

    task automatic test_hazard();
        for (int i = 0; i <= 6; i++) begin
            idle();
            pipe(5'd2, 32'h22);
            if (i == 0) begin bus.div_done = 1'b1; bus.div_rd = 5'd9; bus.div_result = 32'h99; end
            #1;
            vectors++; if (bus.raw_hazard !== 1'b0) begin errors++; $display("FAIL haz_r0[%0d]: got %0b required 0", i, bus.raw_hazard); end
            bus.rs2 = 5'd9;
            #1;
            vectors++; if (bus.raw_hazard !== (i <= 5))
                begin errors++; $display("FAIL haz_rs2[%0d]: got %0b required %0b", i, bus.raw_hazard, (i <= 5)); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_full_clear();
        for (int i = 0; i <= 3; i++) begin
            idle();
            pipe(5'd7, 32'h77);
            if (i == 0) begin bus.div_done = 1'b1; bus.div_rd = 5'd10; bus.div_result = 32'hA0; end
            if (i == 3) begin bus.div_done = 1'b1; bus.div_rd = 5'd11; bus.div_result = 32'hB0; end
            tick();
        end
        idle();
        pipe(5'd7, 32'h77);
        #1;
        vectors++; if (bus.buf_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b required 1", bus.buf_full); end
        vectors++; if (bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL full_hold: got %0b required 1", bus.pipe_hold); end
        tick();
        vectors++; if ({bus.wb_valid, bus.wb_rd} !== {1'b1, 5'd10})
            begin errors++; $display("FAIL full_pop: got %0b/%0d required 1/10", bus.wb_valid, bus.wb_rd); end
        bus.clear = 1'b1;
        bus.div_done = 1'b1; bus.div_rd = 5'd12; bus.div_result = 32'hC0;
        tick();
        idle();
        bus.rs1 = 5'd12; bus.rs2 = 5'd11;
        #1;
        vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %0b required 0", bus.wb_valid); end
        vectors++; if (bus.buf_full !== 1'b0) begin errors++; $display("FAIL clr_full: got %0b required 0", bus.buf_full); end
        vectors++; if (bus.raw_hazard !== 1'b0) begin errors++; $display("FAIL clr_haz: got %0b required 0", bus.raw_hazard); end
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL clr_stale: got %0b required 0", bus.wb_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 3; i++) begin
            idle();
            pipe(5'd8, 32'h88);
            if (i == 0) begin bus.div_done = 1'b1; bus.div_rd = 5'd13; bus.div_result = 32'hD0; end
            if (i == 3) begin bus.div_done = 1'b1; bus.div_rd = 5'd14; bus.div_result = 32'hE0; end
            tick();
        end
        idle();
        pipe(5'd8, 32'h88);
        #2 rst = 1'b0;
        #1;
        vectors++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b0, 5'd0, 32'd0})
            begin errors++; $display("FAIL arst_wb: got %0b/%0d/%0h required 0/0/0", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        vectors++; if (bus.buf_full !== 1'b0) begin errors++; $display("FAIL arst_full: got %0b required 0", bus.buf_full); end
        vectors++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL arst_hold: got %0b required 0", bus.pipe_hold); end
        reset_model();
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL arst_stale[%0d]: got %0b required 0", i, bus.wb_valid); end
        end
    endtask

    task automatic test_random();
        int gap;
        gap = 3;
        for (int i = 0; i < 600; i++) begin
            bus.clear       = ($urandom_range(0, 39) == 0);
            bus.pipe_valid  = ($urandom_range(0, 3) != 0);
            bus.pipe_we     = ($urandom_range(0, 5) != 0);
            bus.pipe_rd     = 5'($urandom_range(0, 7));
            bus.pipe_data   = $urandom;
            bus.div_done    = (gap >= 3) && ($urandom_range(0, 2) == 0);
            bus.div_rd      = 5'($urandom_range(0, 7));
            bus.div_result  = $urandom;
            bus.div_stall   = $urandom_range(0, 1) == 1;
            bus.div_busy_rd = 5'($urandom_range(0, 7));
            bus.rs1         = 5'($urandom_range(0, 7));
            bus.rs2         = 5'($urandom_range(0, 7));
            gap = bus.div_done ? 1 : gap + 1;
            #1;
            model_comb();
            vectors++; if (bus.pipe_hold !== m_hold) begin errors++; $display("FAIL rnd_hold[%0d]: got %0b required %0b", i, bus.pipe_hold, m_hold); end
            vectors++; if (bus.raw_hazard !== m_haz) begin errors++; $display("FAIL rnd_haz[%0d]: got %0b required %0b", i, bus.raw_hazard, m_haz); end
            vectors++; if (bus.buf_full !== m_full) begin errors++; $display("FAIL rnd_full[%0d]: got %0b required %0b", i, bus.buf_full, m_full); end
            tick();
            vectors++; if (bus.wb_valid !== e_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b required %0b", i, bus.wb_valid, e_valid); end
            vectors++; if (bus.wb_rd !== e_rd) begin errors++; $display("FAIL rnd_rd[%0d]: got %0d required %0d", i, bus.wb_rd, e_rd); end
            vectors++; if (bus.wb_data !== e_data) begin errors++; $display("FAIL rnd_data[%0d]: got %0h required %0h", i, bus.wb_data, e_data); end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        idle();
        reset_model();
        #2 rst = 1'b0;
        test_reset();
        test_single_div();
        test_coincident();
        test_starve();
        test_hazard();
        test_full_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
